// File: rtl/uart_param_pkg.sv
// uart_param_pkg: parity encodings, FSM state types and bit-timing helpers shared by TX and RX.
// Parity support is compiled in only when UART_PARAM_PARITY_EN is defined.
package uart_param_pkg;

    localparam int PRESCALE_SHIFT = 3;
    localparam int CNT_W          = 16 + PRESCALE_SHIFT;

    localparam logic [1:0] PARITY_NONE     = 2'b00;
    localparam logic [1:0] PARITY_EVEN     = 2'b01;
    localparam logic [1:0] PARITY_ODD      = 2'b10;
    localparam logic [1:0] PARITY_NONE_ALT = 2'b11;

`ifdef UART_PARAM_PARITY_EN
    localparam bit PARITY_BUILD = 1'b1;
`else
    localparam bit PARITY_BUILD = 1'b0;
`endif

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

    // Counters run down to zero, so these return the reload value (length - 1).
    function automatic logic [CNT_W-1:0] bit_period_m1(input logic [15:0] prescale);
        logic [15:0] eff;
        eff = (prescale == 16'd0) ? 16'd1 : prescale;
        return ({3'b000, eff} << PRESCALE_SHIFT) - CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] bit_half_m1(input logic [15:0] prescale);
        logic [15:0] eff;
        eff = (prescale == 16'd0) ? 16'd1 : prescale;
        return ({3'b000, eff} << (PRESCALE_SHIFT - 1)) - CNT_W'(1);
    endfunction

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode != PARITY_NONE) && (mode != PARITY_NONE_ALT);
    endfunction

    function automatic logic parity_bit(input logic data_xor, input logic [1:0] mode);
        return (mode == PARITY_EVEN) ? data_xor : ~data_xor;
    endfunction

endpackage

// File: rtl/uart_param_rx.sv
// uart_param_rx: synchronised, mid-bit sampling UART receiver with AXI-Stream style output.
// State | meaning: IDLE wait edge | START confirm start | DATA data bits | PARITY parity bit | STOP first stop bit
module uart_param_rx
    import uart_param_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic [1:0]            parity_mode,
    input  logic [15:0]           prescale,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  rx_busy,
    output logic                  rx_overrun_error,
    output logic                  rx_frame_error,
    output logic                  rx_parity_error
);

    rx_state_e             state_q, state_d;
    logic                  sync1_q, sync2_q, last_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d, period_q, period_d;
    logic [3:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, tdata_q, tdata_d;
    logic [1:0]            mode_q, mode_d;
    logic                  perr_q, perr_d, valid_q, valid_d, busy_q, busy_d;
    logic                  ovr_q, ovr_d, fe_q, fe_d, pe_q, pe_d;
    logic                  tick, par_en;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        mode_d   = mode_q;
        perr_d   = perr_q;
        tdata_d  = tdata_q;
        valid_d  = valid_q && !m_axis_tready;
        ovr_d    = 1'b0;
        fe_d     = 1'b0;
        pe_d     = 1'b0;
        tick     = (cnt_q == '0);
        par_en   = PARITY_BUILD && parity_enabled(mode_q);
        if (state_q != RX_IDLE) begin
            cnt_d = tick ? period_q : cnt_q - CNT_W'(1);
        end
        case (state_q)
            RX_IDLE: begin
                if (last_q && !sync2_q) begin
                    state_d  = RX_START;
                    cnt_d    = bit_half_m1(prescale);
                    period_d = bit_period_m1(prescale);
                    mode_d   = parity_mode;
                    perr_d   = 1'b0;
                end
            end
            RX_START: begin
                if (tick) begin
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                    bit_d   = '0;
                end
            end
            RX_DATA: begin
                if (tick) begin
                    shift_d = {sync2_q, shift_q[DATA_WIDTH-1:1]};
                    if (bit_q == 4'(DATA_WIDTH - 1)) begin
                        state_d = par_en ? RX_PARITY : RX_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (tick) begin
                    perr_d  = (sync2_q != parity_bit(^shift_q, mode_q));
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                // Only the first stop bit is checked; a second one overlaps idle.
                if (tick) begin
                    state_d = RX_IDLE;
                    fe_d    = !sync2_q;
                    pe_d    = perr_q;
                    if (sync2_q && !perr_q) begin
                        tdata_d = shift_q;
                        ovr_d   = valid_q && !m_axis_tready;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
        busy_d = (state_d != RX_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            last_q   <= 1'b1;
            state_q  <= RX_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            mode_q   <= PARITY_NONE;
            perr_q   <= 1'b0;
            tdata_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
            fe_q     <= 1'b0;
            pe_q     <= 1'b0;
        end else begin
            sync1_q  <= rxd;
            sync2_q  <= sync1_q;
            last_q   <= sync2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            mode_q   <= mode_d;
            perr_q   <= perr_d;
            tdata_q  <= tdata_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
            fe_q     <= fe_d;
            pe_q     <= pe_d;
        end
    end

    assign m_axis_tdata     = tdata_q;
    assign m_axis_tvalid    = valid_q;
    assign rx_busy          = busy_q;
    assign rx_overrun_error = ovr_q;
    assign rx_frame_error   = fe_q;
    assign rx_parity_error  = PARITY_BUILD && pe_q;

endmodule

// File: rtl/uart_param.sv
// uart_param: parameterised UART; TX FSM inline, RX in uart_param_rx. Parity needs UART_PARAM_PARITY_EN.
// State | meaning: IDLE ready | START start bit | DATA data bits | PARITY parity bit | STOP stop bits
module uart_param
    import uart_param_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  txd,
    output logic                  tx_busy,
    output logic                  rx_busy,
    output logic                  rx_overrun_error,
    output logic                  rx_frame_error,
    output logic                  rx_parity_error,
    input  logic [1:0]            parity_mode,
    input  logic [15:0]           prescale
);

    tx_state_e             tx_state_q, tx_state_d;
    logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d, tx_period_q, tx_period_d;
    logic [3:0]            tx_bit_q, tx_bit_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_par_en_q, tx_par_en_d, tx_par_q, tx_par_d;
    logic                  txd_q, txd_d, tready_q, tready_d, tx_busy_q, tx_busy_d;
    logic                  tx_tick;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_period_d = tx_period_q;
        tx_bit_d    = tx_bit_q;
        tx_data_d   = tx_data_q;
        tx_par_en_d = tx_par_en_q;
        tx_par_d    = tx_par_q;
        txd_d       = txd_q;
        tready_d    = 1'b0;
        tx_busy_d   = tx_busy_q;
        tx_tick     = (tx_cnt_q == '0);
        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = tx_tick ? tx_period_q : tx_cnt_q - CNT_W'(1);
        end
        case (tx_state_q)
            TX_IDLE: begin
                if (s_axis_tvalid && tready_q) begin
                    // Frame configuration is frozen here for the whole frame.
                    tx_state_d  = TX_START;
                    txd_d       = 1'b0;
                    tx_busy_d   = 1'b1;
                    tx_data_d   = s_axis_tdata;
                    tx_period_d = bit_period_m1(prescale);
                    tx_cnt_d    = bit_period_m1(prescale);
                    tx_par_en_d = PARITY_BUILD && parity_enabled(parity_mode);
                    tx_par_d    = parity_bit(^s_axis_tdata, parity_mode);
                end else begin
                    tready_d = 1'b1;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_state_d = TX_DATA;
                    txd_d      = tx_data_q[0];
                    tx_bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    if (tx_bit_q == 4'(DATA_WIDTH - 1)) begin
                        tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP;
                        txd_d      = tx_par_en_q ? tx_par_q : 1'b1;
                        tx_bit_d   = '0;
                    end else begin
                        tx_data_d = tx_data_q >> 1;
                        txd_d     = tx_data_q[1];
                        tx_bit_d  = tx_bit_q + 4'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_tick) begin
                    tx_state_d = TX_STOP;
                    txd_d      = 1'b1;
                    tx_bit_d   = '0;
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    if (tx_bit_q == 4'(STOP_BITS - 1)) begin
                        tx_state_d = TX_IDLE;
                        tx_busy_d  = 1'b0;
                        tready_d   = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                txd_d      = 1'b1;
                tx_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_period_q <= '0;
            tx_bit_q    <= '0;
            tx_data_q   <= '0;
            tx_par_en_q <= 1'b0;
            tx_par_q    <= 1'b0;
            txd_q       <= 1'b1;
            tready_q    <= 1'b0;
            tx_busy_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_period_q <= tx_period_d;
            tx_bit_q    <= tx_bit_d;
            tx_data_q   <= tx_data_d;
            tx_par_en_q <= tx_par_en_d;
            tx_par_q    <= tx_par_d;
            txd_q       <= txd_d;
            tready_q    <= tready_d;
            tx_busy_q   <= tx_busy_d;
        end
    end

    assign txd           = txd_q;
    assign s_axis_tready = tready_q;
    assign tx_busy       = tx_busy_q;

    uart_param_rx #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rx (
        .clk              (clk),
        .rst              (rst),
        .rxd              (rxd),
        .parity_mode      (parity_mode),
        .prescale         (prescale),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .rx_busy          (rx_busy),
        .rx_overrun_error (rx_overrun_error),
        .rx_frame_error   (rx_frame_error),
        .rx_parity_error  (rx_parity_error)
    );

endmodule
